// File: rtl/mem_wb_pipe_reg.sv
// Multi-lane MEM/WB pipeline register with valid/ready handshake, one-entry skid
// buffer, per-lane kill, whole-stage flush and a saturating bubble counter.
module mem_wb_pipe_reg #(
    parameter int LANES = 2,
    parameter int WIDTH = 104,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_kill,
    output logic                   in_ready,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic [CNT_W-1:0]       bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [LANES-1:0]       main_valid_q, main_valid_d;
    logic [LANES*WIDTH-1:0] main_data_q, main_data_d;
    logic [LANES-1:0]       skid_valid_q, skid_valid_d;
    logic [LANES*WIDTH-1:0] skid_data_q, skid_data_d;
    logic                   in_ready_q, in_ready_d;
    logic [CNT_W-1:0]       bubble_q, bubble_d;

    logic [LANES-1:0] in_live_s;
    logic             accept_s;
    logic             fire_s;

    // Handshake qualifiers; killed lanes still carry payload but never count as valid.
    always_comb begin
        in_live_s = in_valid & ~in_kill;
        accept_s  = in_ready_q & (|in_live_s) & ~flush;
        fire_s    = out_ready & (|main_valid_q);
    end

    // Next-state for the bundle storage; flush overrides everything else.
    always_comb begin
        state_d      = state_q;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            state_d      = ST_EMPTY;
            main_valid_d = '0;
            skid_valid_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_valid_d = in_live_s;
                        main_data_d  = in_data;
                        state_d      = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && fire_s) begin
                        main_valid_d = in_live_s;
                        main_data_d  = in_data;
                    end else if (accept_s) begin
                        skid_valid_d = in_live_s;
                        skid_data_d  = in_data;
                        state_d      = ST_TWO;
                    end else if (fire_s) begin
                        main_valid_d = '0;
                        state_d      = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (fire_s) begin
                        main_valid_d = skid_valid_q;
                        main_data_d  = skid_data_q;
                        skid_valid_d = '0;
                        state_d      = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_valid_d = '0;
                    skid_valid_d = '0;
                end
            endcase
        end
    end

    // Ready is registered from the next state so it never depends on out_ready combinationally.
    always_comb begin
        in_ready_d = (state_d != ST_TWO);
    end

    // Saturating count of cycles where downstream was ready but nothing was offered.
    always_comb begin
        bubble_d = bubble_q;
        if (!flush && out_ready && (main_valid_q == '0) && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubble_d = bubble_q;
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            main_valid_q <= '0;
            main_data_q  <= '0;
            skid_valid_q <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            bubble_q     <= '0;
        end else begin
            state_q      <= state_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            bubble_q     <= bubble_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid_q;
    assign out_data   = main_data_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed, table-driven bench for mem_wb_pipe_reg (2 lanes, 104-bit payload, 4-bit counter).
module tb_mem_wb_pipe_reg;

    localparam int LANES = 2;
    localparam int WIDTH = 104;
    localparam int CNT_W = 4;
    localparam int NV    = 20;

    logic                   clk;
    logic                   rst;
    logic [LANES-1:0]       in_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic [LANES-1:0]       in_kill;
    logic                   in_ready;
    logic [LANES-1:0]       out_valid;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   out_ready;
    logic                   flush;
    logic [CNT_W-1:0]       bubble_cnt;

    int total;
    int bad;

    typedef struct {
        logic [1:0]  iv;
        logic [1:0]  ik;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic [1:0]  eov;
        logic [31:0] epc;
        logic        eir;
        logic [3:0]  ebub;
    } vec_t;

    vec_t vecs [NV];

    mem_wb_pipe_reg #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_kill    (in_kill),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flush      (flush),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] lane_data(input logic [31:0] pc, input logic [31:0] lane);
        return {40'h0, lane, pc};
    endfunction

    function automatic logic [LANES*WIDTH-1:0] bundle(input logic [31:0] pc);
        return {lane_data(pc, 32'd1), lane_data(pc, 32'd0)};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // {iv, ik, pc, ordy, flush, exp out_valid, exp pc, exp in_ready, exp bubble}
        vecs[0]  = '{2'b11, 2'b00, 32'h100, 1'b1, 1'b0, 2'b11, 32'h100, 1'b1, 4'd1};
        vecs[1]  = '{2'b11, 2'b00, 32'h104, 1'b1, 1'b0, 2'b11, 32'h104, 1'b1, 4'd1};
        vecs[2]  = '{2'b11, 2'b00, 32'h108, 1'b1, 1'b0, 2'b11, 32'h108, 1'b1, 4'd1};
        vecs[3]  = '{2'b11, 2'b00, 32'h10c, 1'b1, 1'b0, 2'b11, 32'h10c, 1'b1, 4'd1};
        vecs[4]  = '{2'b11, 2'b00, 32'h110, 1'b0, 1'b0, 2'b11, 32'h10c, 1'b0, 4'd1};
        vecs[5]  = '{2'b11, 2'b00, 32'h114, 1'b0, 1'b0, 2'b11, 32'h10c, 1'b0, 4'd1};
        vecs[6]  = '{2'b11, 2'b00, 32'h114, 1'b1, 1'b0, 2'b11, 32'h110, 1'b1, 4'd1};
        vecs[7]  = '{2'b00, 2'b00, 32'h0,   1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 4'd1};
        vecs[8]  = '{2'b11, 2'b10, 32'h200, 1'b0, 1'b0, 2'b01, 32'h200, 1'b1, 4'd1};
        vecs[9]  = '{2'b01, 2'b01, 32'h300, 1'b0, 1'b0, 2'b01, 32'h200, 1'b1, 4'd1};
        vecs[10] = '{2'b01, 2'b01, 32'h304, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 4'd1};
        vecs[11] = '{2'b01, 2'b01, 32'h308, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 4'd2};
        vecs[12] = '{2'b01, 2'b01, 32'h30c, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 4'd3};
        vecs[13] = '{2'b11, 2'b00, 32'h400, 1'b0, 1'b0, 2'b11, 32'h400, 1'b1, 4'd3};
        vecs[14] = '{2'b11, 2'b00, 32'h404, 1'b0, 1'b0, 2'b11, 32'h400, 1'b0, 4'd3};
        vecs[15] = '{2'b11, 2'b00, 32'h408, 1'b0, 1'b1, 2'b00, 32'h0,   1'b1, 4'd3};
        vecs[16] = '{2'b00, 2'b00, 32'h0,   1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 4'd4};
        vecs[17] = '{2'b00, 2'b00, 32'h0,   1'b1, 1'b1, 2'b00, 32'h0,   1'b1, 4'd4};
        vecs[18] = '{2'b11, 2'b00, 32'h500, 1'b1, 1'b1, 2'b00, 32'h0,   1'b1, 4'd4};
        vecs[19] = '{2'b00, 2'b00, 32'h0,   1'b0, 1'b0, 2'b00, 32'h0,   1'b1, 4'd4};

        rst       = 1'b1;
        in_valid  = '0;
        in_kill   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #3;
        chk("reset_out_valid", 256'(out_valid), 256'(2'b00));
        chk("reset_out_data", 256'(out_data), 256'(0));
        chk("reset_in_ready", 256'(in_ready), 256'(1'b1));
        chk("reset_bubble", 256'(bubble_cnt), 256'(4'd0));
        #9;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            in_valid  = vecs[i].iv;
            in_kill   = vecs[i].ik;
            in_data   = bundle(vecs[i].pc);
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 256'(out_valid), 256'(vecs[i].eov));
            if (vecs[i].eov != 2'b00) begin
                chk($sformatf("vec%0d_out_data", i), 256'(out_data), 256'(bundle(vecs[i].epc)));
            end
            chk($sformatf("vec%0d_in_ready", i), 256'(in_ready), 256'(vecs[i].eir));
            chk($sformatf("vec%0d_bubble", i), 256'(bubble_cnt), 256'(vecs[i].ebub));
        end

        // Fill main and skid, then pulse reset between clock edges.
        flush     = 1'b0;
        in_kill   = 2'b00;
        in_valid  = 2'b11;
        out_ready = 1'b0;
        in_data   = bundle(32'h600);
        @(posedge clk);
        #1;
        in_data = bundle(32'h604);
        @(posedge clk);
        #1;
        chk("two_in_ready", 256'(in_ready), 256'(1'b0));
        in_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 256'(out_valid), 256'(2'b00));
        chk("async_rst_out_data", 256'(out_data), 256'(0));
        chk("async_rst_in_ready", 256'(in_ready), 256'(1'b1));
        chk("async_rst_bubble", 256'(bubble_cnt), 256'(4'd0));
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_empty%0d", i), 256'(out_valid), 256'(2'b00));
        end

        // Saturation from a fresh reset: bubbles accumulate up to 15 and stop.
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d", i), 256'(bubble_cnt), 256'((i > 15) ? 15 : i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
